// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU step sequencer: state codes, PC mux selects
// and the default halt opcode.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_ERROR     = 3'd7
  } seq_state_e;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;

  localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait timer: counts unready cycles; expired flags the cycle in which
// the MEM_TIMEOUT-th consecutive unready cycle is being counted.
module seq_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt;

  assign expired = count && (cnt == W'(MEM_TIMEOUT - 1));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)       cnt <= '0;
    else if (clear) cnt <= '0;
    else if (count) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/cpu_step_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with memory
// handshakes, halt and timeout. Define SEQ_PERF_CNT_EN to add perf counters.
module cpu_step_sequencer
  import cpu_seq_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int         MEM_TIMEOUT = 16,
  parameter int         CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [3:0]       Opcode,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             Zero,
  input  logic             Sig_Mem_Read,
  input  logic             Sig_Mem_Write,
  input  logic             Sig_Reg_Write,
  input  logic             Imem_Ready,
  input  logic             Dmem_Ready,
  output logic             Imem_Req,
  output logic             Ir_Load,
  output logic             Dmem_Req,
  output logic             Dmem_We,
  output logic             Reg_Write_En,
  output logic             Pc_Write,
  output logic [1:0]       Pc_Sel,
  output logic             Busy,
  output logic             Halted,
  output logic             Error,
  output logic [2:0]       State
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] Cycle_Cnt,
  output logic [CNT_W-1:0] Instr_Cnt
`endif
);

  seq_state_e state, state_n;
  logic       tmr_clear, tmr_count, tmr_expired;

  seq_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmr (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (tmr_clear),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Timer only runs while a request is outstanding and unanswered; any other
  // cycle clears it, which covers clearing on entry to FETCH/MEMORY.
  always_comb begin
    state_n      = state;
    Imem_Req     = 1'b0;
    Ir_Load      = 1'b0;
    Dmem_Req     = 1'b0;
    Dmem_We      = 1'b0;
    Reg_Write_En = 1'b0;
    Pc_Write     = 1'b0;
    Pc_Sel       = PC_SEL_INC;
    tmr_clear    = 1'b1;
    tmr_count    = 1'b0;
    case (state)
      ST_IDLE: if (Start) state_n = ST_FETCH;
      ST_FETCH: begin
        Imem_Req = 1'b1;
        if (Imem_Ready) begin
          Ir_Load = 1'b1;
          state_n = ST_DECODE;
        end else begin
          tmr_clear = 1'b0;
          tmr_count = 1'b1;
          if (tmr_expired) state_n = ST_ERROR;
        end
      end
      ST_DECODE: state_n = (Opcode == HALT_OPCODE) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: begin
        if (Jump) begin
          Pc_Write = 1'b1;
          Pc_Sel   = PC_SEL_JMP;
          state_n  = ST_FETCH;
        end else if (Branch) begin
          Pc_Write = 1'b1;
          Pc_Sel   = Zero ? PC_SEL_BR : PC_SEL_INC;
          state_n  = ST_FETCH;
        end else if (Sig_Mem_Read || Sig_Mem_Write) begin
          state_n  = ST_MEMORY;
        end else if (Sig_Reg_Write) begin
          state_n  = ST_WRITEBACK;
        end else begin
          Pc_Write = 1'b1;
          state_n  = ST_FETCH;
        end
      end
      ST_MEMORY: begin
        Dmem_Req = 1'b1;
        Dmem_We  = Sig_Mem_Write;
        if (Dmem_Ready) begin
          if (Sig_Mem_Read) begin
            state_n = ST_WRITEBACK;
          end else begin
            Pc_Write = 1'b1;
            state_n  = ST_FETCH;
          end
        end else begin
          tmr_clear = 1'b0;
          tmr_count = 1'b1;
          if (tmr_expired) state_n = ST_ERROR;
        end
      end
      ST_WRITEBACK: begin
        Reg_Write_En = 1'b1;
        Pc_Write     = 1'b1;
        state_n      = ST_FETCH;
      end
      default: state_n = state;
    endcase
  end

  assign Busy   = !(state inside {ST_IDLE, ST_HALT, ST_ERROR});
  assign Halted = (state == ST_HALT);
  assign Error  = (state == ST_ERROR);
  assign State  = state;

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Cycle_Cnt <= '0;
      Instr_Cnt <= '0;
    end else begin
      if (Busy && !(&Cycle_Cnt))     Cycle_Cnt <= Cycle_Cnt + CNT_W'(1);
      if (Pc_Write && !(&Instr_Cnt)) Instr_Cnt <= Instr_Cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Random instruction stream against a per-instruction outcome model, scored
// by a monitor at each Pc_Write, plus directed halt/timeout/reset cases.
module tb_cpu_step_sequencer;
  import cpu_seq_pkg::*;

  logic       Clk = 1'b0, Rst = 1'b0, Start = 1'b0;
  logic [3:0] Opcode = 4'h0;
  logic       Jump = 1'b0, Branch = 1'b0, Zero = 1'b0;
  logic       Sig_Mem_Read = 1'b0, Sig_Mem_Write = 1'b0, Sig_Reg_Write = 1'b0;
  logic       Imem_Ready = 1'b0, Dmem_Ready = 1'b0;
  logic       Imem_Req, Ir_Load, Dmem_Req, Dmem_We, Reg_Write_En, Pc_Write;
  logic [1:0] Pc_Sel;
  logic       Busy, Halted, Error;
  logic [2:0] State;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] Cycle_Cnt, Instr_Cnt;
`endif

  always #5 Clk = ~Clk;

  cpu_step_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Opcode(Opcode),
    .Jump(Jump), .Branch(Branch), .Zero(Zero),
    .Sig_Mem_Read(Sig_Mem_Read), .Sig_Mem_Write(Sig_Mem_Write),
    .Sig_Reg_Write(Sig_Reg_Write), .Imem_Ready(Imem_Ready), .Dmem_Ready(Dmem_Ready),
    .Imem_Req(Imem_Req), .Ir_Load(Ir_Load), .Dmem_Req(Dmem_Req), .Dmem_We(Dmem_We),
    .Reg_Write_En(Reg_Write_En), .Pc_Write(Pc_Write), .Pc_Sel(Pc_Sel),
    .Busy(Busy), .Halted(Halted), .Error(Error), .State(State)
`ifdef SEQ_PERF_CNT_EN
    , .Cycle_Cnt(Cycle_Cnt), .Instr_Cnt(Instr_Cnt)
`endif
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected observable outcome of one instruction
  typedef struct {
    logic [1:0] sel;
    int         regw;
    int         dcyc;
    int         wecyc;
    int         icyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  bit   mon_en = 0;
  int   ic = 0, dc = 0, wc = 0, rw = 0;

  always @(negedge Clk) begin
    #2;
    if (mon_en) begin
      if (Imem_Req) ic++;
      if (Dmem_Req) dc++;
      if (Dmem_Req && Dmem_We) wc++;
      if (Reg_Write_En) rw++;
      if (Pc_Write) begin
        if (sbq.size() == 0) check("pc_write_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = sbq.pop_front();
          check("pc_sel", {30'd0, Pc_Sel}, {30'd0, mon_e.sel});
          check("reg_we_pulses", rw, mon_e.regw);
          check("dmem_req_cycles", dc, mon_e.dcyc);
          check("dmem_we_cycles", wc, mon_e.wecyc);
          check("imem_req_cycles", ic, mon_e.icyc);
        end
        ic = 0; dc = 0; wc = 0; rw = 0;
      end
    end
  end

  task automatic wait_req(input bit dmem, output bit ok);
    ok = 0;
    for (int n = 0; n < 60; n++) begin
      if (dmem ? Dmem_Req : Imem_Req) begin
        ok = 1;
        return;
      end
      @(negedge Clk);
    end
  endtask

  task automatic clear_cu();
    Opcode = 4'h1; Jump = 0; Branch = 0; Zero = 0;
    Sig_Mem_Read = 0; Sig_Mem_Write = 0; Sig_Reg_Write = 0;
    Imem_Ready = 0; Dmem_Ready = 0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 0; Start = 0;
    clear_cu();
    #1;
    check("reset_outputs",
          {19'd0, Imem_Req, Ir_Load, Dmem_Req, Dmem_We, Reg_Write_En, Pc_Write,
           Pc_Sel, Busy, Halted, Error, State}, 32'd0);
    @(negedge Clk);
    Rst = 1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (vectors %0d)", vectors);
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          kind, il, dl, cnt, pcw;
    logic [31:0] noise;
    exp_t        e;

    do_reset();
    // Ready strobes without a request must not move the sequencer
    Imem_Ready = 1; Dmem_Ready = 1;
    repeat (2) @(negedge Clk);
    #1;
    check("idle_ignores_ready", {29'd0, State}, 32'd0);
    check("idle_no_req", {30'd0, Imem_Req, Dmem_Req}, 32'd0);
    Imem_Ready = 0; Dmem_Ready = 0;

    // Random instruction stream
    @(negedge Clk);
    mon_en = 1; ic = 0; dc = 0; wc = 0; rw = 0;
    Start = 1;
    for (int i = 0; i < 40; i++) begin
      wait_req(0, ok);
      if (!ok) begin
        check("wait_imem_req", 32'd0, 32'd1);
        break;
      end
      kind  = $urandom_range(0, 5);
      il    = $urandom_range(0, 3);
      dl    = $urandom_range(0, 4);
      noise = $urandom();
      Opcode = 4'($urandom_range(0, 14));
      Jump = 0; Branch = 0; Sig_Mem_Read = 0; Sig_Mem_Write = 0; Sig_Reg_Write = 0;
      Zero = noise[8];
      e.sel = PC_SEL_INC; e.regw = 0; e.dcyc = 0; e.wecyc = 0; e.icyc = il + 1;
      case (kind)
        0: begin Sig_Reg_Write = 1; e.regw = 1; end
        1: ;
        2: begin
          Sig_Mem_Read = 1; Sig_Reg_Write = noise[0];
          e.regw = 1; e.dcyc = dl + 1;
        end
        3: begin
          Sig_Mem_Write = 1; Sig_Reg_Write = noise[0];
          e.dcyc = dl + 1; e.wecyc = dl + 1;
        end
        4: begin
          Branch = 1; Sig_Mem_Read = noise[0]; Sig_Reg_Write = noise[1];
          e.sel = Zero ? PC_SEL_BR : PC_SEL_INC;
        end
        default: begin
          Jump = 1; Branch = noise[0]; Sig_Mem_Write = noise[1]; Sig_Reg_Write = noise[2];
          e.sel = PC_SEL_JMP;
        end
      endcase
      sbq.push_back(e);
      repeat (il) @(negedge Clk);
      Imem_Ready = 1;
      @(negedge Clk);
      Imem_Ready = 0;
      if (kind == 2 || kind == 3) begin
        wait_req(1, ok);
        if (!ok) begin
          check("wait_dmem_req", 32'd0, 32'd1);
          break;
        end
        repeat (dl) @(negedge Clk);
        Dmem_Ready = 1;
        @(negedge Clk);
        Dmem_Ready = 0;
      end
    end
    cnt = 0;
    while (sbq.size() != 0 && cnt < 60) begin
      @(negedge Clk);
      cnt++;
    end
    check("scoreboard_drained", sbq.size(), 32'd0);
    @(negedge Clk);
    mon_en = 0;

    // Halt: no PC update, sticky, Start ignored, cleared only by reset
    do_reset();
    Start = 1; Opcode = 4'hF; Imem_Ready = 1;
    pcw = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge Clk);
      #1;
      if (Pc_Write) pcw++;
    end
    check("halt_state", {29'd0, State}, {29'd0, ST_HALT});
    check("halt_flags", {29'd0, Halted, Busy, Error}, 32'd4);
    check("halt_no_pc_write", pcw, 32'd0);
    #1 Rst = 0;
    #1;
    check("halt_reset_state", {29'd0, State}, 32'd0);
    check("halt_reset_halted", {31'd0, Halted}, 32'd0);
    @(negedge Clk);
    Rst = 1;

    // Fetch timeout
    do_reset();
    Start = 1; Imem_Ready = 0;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clk);
      #1;
      if (Error) break;
      if (Imem_Req) cnt++;
    end
    check("timeout_fetch_cycles", cnt, 32'd16);
    check("timeout_error", {31'd0, Error}, 32'd1);
    Start = 0;
    @(negedge Clk);
    Start = 1; Imem_Ready = 1;
    repeat (3) @(negedge Clk);
    #1;
    check("error_sticky_state", {29'd0, State}, {29'd0, ST_ERROR});
    check("error_strobes", {26'd0, Imem_Req, Ir_Load, Dmem_Req, Pc_Write, Busy, Halted}, 32'd0);

    // Async reset in the middle of a data access
    do_reset();
    Start = 1; Sig_Mem_Read = 1; Sig_Reg_Write = 1;
    @(negedge Clk);
    wait_req(0, ok);
    check("mid_mem_fetch_seen", {31'd0, ok}, 32'd1);
    Imem_Ready = 1;
    @(negedge Clk);
    Imem_Ready = 0;
    wait_req(1, ok);
    check("mid_mem_dreq_seen", {31'd0, ok}, 32'd1);
    #2 Rst = 0;
    #1;
    check("mid_mem_dreq_dropped", {31'd0, Dmem_Req}, 32'd0);
    check("mid_mem_state", {29'd0, State}, 32'd0);
    @(negedge Clk);
    Rst = 1;

`ifdef SEQ_PERF_CNT_EN
    // Three zero-wait ALU ops: 4 busy cycles each
    do_reset();
    Sig_Reg_Write = 1; Imem_Ready = 1; Start = 1;
    cnt = 0; pcw = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge Clk);
      #1;
      if (pcw == 3) break;
      if (Busy) cnt++;
      if (Pc_Write) pcw++;
    end
    check("perf_instr_cnt", Instr_Cnt, 32'd3);
    check("perf_cycle_cnt", Cycle_Cnt, 32'd12);
    check("perf_cycle_vs_busy", Cycle_Cnt, cnt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
